// File: rtl/rx_dma_sched_if.sv
// rtl/rx_dma_sched_if.sv - host config, DMA control and status signals of rx_dma_sched
// Optional watchdog port is present when RX_DMA_SCHED_WATCHDOG_EN is defined.
interface rx_dma_sched_if #(
  parameter int ADDR_W = 48,
  parameter int REL_W  = 8,
  parameter int BLK_W  = 16
);
  logic              cfg_start;
  logic              cfg_stop;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [31:0]       cfg_ring_bytes;
  logic [31:0]       cfg_ring_bursts;
  logic [8:0]        cfg_burst_len;
  logic [16:0]       cfg_block_bytes;
  logic [7:0]        cfg_blocks_per_irq;
`ifdef RX_DMA_SCHED_WATCHDOG_EN
  logic [31:0]       cfg_watchdog_cycles;
`endif
  logic              host_release;
  logic              dma_write_enable;
  logic [ADDR_W-1:0] dma_write_base_address;
  logic [31:0]       dma_write_burst_count;
  logic [8:0]        dma_write_burst_len;
  logic [31:0]       dma_write_ddr_size;
  logic [16:0]       dma_write_access_size_bytes;
  logic              dma_write_access_tick;
  logic              dma_write_access_tick_ack;
  logic              dma_write_burst_tick;
  logic              dma_write_busy;
  logic              dma_write_overflow_ins;
  logic [1:0]        dma_write_bresp;
  logic [2:0]        state;
  logic [BLK_W-1:0]  blocks_ready;
  logic [REL_W-1:0]  release_pending;
  logic [BLK_W-1:0]  overflow_count;
  logic              cfg_error;
  logic              irq_block;
  logic              irq_overflow;
  logic              irq_error;
  logic              irq_stall;

  modport slave (
    input  cfg_start, cfg_stop, cfg_base_addr, cfg_ring_bytes, cfg_ring_bursts,
           cfg_burst_len, cfg_block_bytes, cfg_blocks_per_irq,
`ifdef RX_DMA_SCHED_WATCHDOG_EN
           cfg_watchdog_cycles,
`endif
           host_release, dma_write_access_tick_ack, dma_write_burst_tick,
           dma_write_busy, dma_write_overflow_ins, dma_write_bresp,
    output dma_write_enable, dma_write_base_address, dma_write_burst_count,
           dma_write_burst_len, dma_write_ddr_size, dma_write_access_size_bytes,
           dma_write_access_tick, state, blocks_ready, release_pending,
           overflow_count, cfg_error, irq_block, irq_overflow, irq_error, irq_stall
  );

  modport master (
    output cfg_start, cfg_stop, cfg_base_addr, cfg_ring_bytes, cfg_ring_bursts,
           cfg_burst_len, cfg_block_bytes, cfg_blocks_per_irq,
`ifdef RX_DMA_SCHED_WATCHDOG_EN
           cfg_watchdog_cycles,
`endif
           host_release, dma_write_access_tick_ack, dma_write_burst_tick,
           dma_write_busy, dma_write_overflow_ins, dma_write_bresp,
    input  dma_write_enable, dma_write_base_address, dma_write_burst_count,
           dma_write_burst_len, dma_write_ddr_size, dma_write_access_size_bytes,
           dma_write_access_tick, state, blocks_ready, release_pending,
           overflow_count, cfg_error, irq_block, irq_overflow, irq_error, irq_stall
  );
endinterface

// File: rtl/rx_dma_sched.sv
// rtl/rx_dma_sched.sv - RX write DMA control-plane sequencer
// Optional stall watchdog enabled by defining RX_DMA_SCHED_WATCHDOG_EN.
module rx_dma_sched #(
  parameter int ADDR_W = 48,
  parameter int REL_W  = 8,
  parameter int BLK_W  = 16
) (
  input logic          aclk,
  input logic          aresetn,
  rx_dma_sched_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       bursts_q, bursts_d;
  logic [31:0]       ring_q, ring_d;
  logic [8:0]        blen_q, blen_d;
  logic [16:0]       blkb_q, blkb_d;
  logic [7:0]        bpi_q, bpi_d;
  logic [17:0]       acc_q, acc_d;
  logic [7:0]        icnt_q, icnt_d;
  logic [BLK_W-1:0]  blocks_q, blocks_d;
  logic [REL_W-1:0]  pend_q, pend_d;
  logic [BLK_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic              tick_q, tick_d;
  logic              btick_q, ovf_q;
  logic              cfg_err_q, cfg_err_d;
  logic              irq_blk_q, irq_blk_d;
  logic              irq_ovf_q, irq_ovf_d;
  logic              irq_err_q, irq_err_d;

  logic [12:0] burst_bytes_in, burst_bytes_sh;
  logic        cfg_valid, btick_rise, ovf_rise, active, rel_done, blk_done, drain_exit;
  logic [17:0] acc_sum;
  logic [7:0]  bpi_eff;
  logic        unused_bresp0;

  assign unused_bresp0  = bus.dma_write_bresp[0];
  assign burst_bytes_in = {bus.cfg_burst_len, 4'b0000};
  assign burst_bytes_sh = {blen_q, 4'b0000};
  assign cfg_valid  = (bus.cfg_burst_len != 9'd0) && (bus.cfg_burst_len <= 9'd256) &&
                      (bus.cfg_ring_bytes != 32'd0) && (bus.cfg_ring_bursts != 32'd0) &&
                      (bus.cfg_block_bytes >= {4'b0000, burst_bytes_in});
  assign btick_rise = bus.dma_write_burst_tick & ~btick_q;
  assign ovf_rise   = bus.dma_write_overflow_ins & ~ovf_q;
  assign active     = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_ERROR);
  assign rel_done   = tick_q & bus.dma_write_access_tick_ack;
  assign acc_sum    = acc_q + {5'b00000, burst_bytes_sh};
  assign blk_done   = (state_q == S_RUN) && btick_rise && (acc_sum >= {1'b0, blkb_q});
  assign bpi_eff    = (bpi_q == 8'd0) ? 8'd1 : bpi_q;
  assign drain_exit = (state_q == S_DRAIN) && !bus.dma_write_busy && !tick_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    irq_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          if (cfg_valid) begin
            state_d   = S_ARM;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ARM:   state_d = S_RUN;
      S_RUN: begin
        if (bus.cfg_stop) begin
          state_d = S_DRAIN;
        end else if (btick_rise && bus.dma_write_bresp[1]) begin
          state_d   = S_ERROR;
          irq_err_d = 1'b1;
        end
      end
      S_DRAIN: if (drain_exit) state_d = S_IDLE;
      S_ERROR: if (bus.cfg_stop) state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d    = base_q;
    bursts_d  = bursts_q;
    ring_d    = ring_q;
    blen_d    = blen_q;
    blkb_d    = blkb_q;
    bpi_d     = bpi_q;
    acc_d     = acc_q;
    icnt_d    = icnt_q;
    blocks_d  = blocks_q;
    pend_d    = pend_q;
    ovf_cnt_d = ovf_cnt_q;
    tick_d    = tick_q;
    irq_blk_d = 1'b0;
    irq_ovf_d = 1'b0;

    if ((state_q == S_IDLE) && bus.cfg_start) begin
      base_d   = bus.cfg_base_addr;
      bursts_d = bus.cfg_ring_bursts;
      ring_d   = bus.cfg_ring_bytes;
      blen_d   = bus.cfg_burst_len;
      blkb_d   = bus.cfg_block_bytes;
      bpi_d    = bus.cfg_blocks_per_irq;
    end

    if ((state_q == S_RUN) && btick_rise) begin
      if (blk_done) begin
        acc_d = acc_sum - {1'b0, blkb_q};
        if (icnt_q + 8'd1 == bpi_eff) begin
          icnt_d    = 8'd0;
          irq_blk_d = 1'b1;
        end else begin
          icnt_d = icnt_q + 8'd1;
        end
      end else begin
        acc_d = acc_sum;
      end
    end

    // A block landing and a release finishing together cancel out.
    case ({blk_done, rel_done})
      2'b10:   if (blocks_q != {BLK_W{1'b1}}) blocks_d = blocks_q + BLK_W'(1);
      2'b01:   if (blocks_q != '0) blocks_d = blocks_q - BLK_W'(1);
      default: blocks_d = blocks_q;
    endcase

    case ({bus.host_release && active, rel_done})
      2'b10:   if (pend_q != {REL_W{1'b1}}) pend_d = pend_q + REL_W'(1);
      2'b01:   if (pend_q != '0) pend_d = pend_q - REL_W'(1);
      default: pend_d = pend_q;
    endcase

    // New request only after the DMA has dropped ack from the previous one.
    if (rel_done) begin
      tick_d = 1'b0;
    end else if (active && !tick_q && !bus.dma_write_access_tick_ack &&
                 (pend_q != '0) && !drain_exit) begin
      tick_d = 1'b1;
    end

    if (ovf_rise) begin
      irq_ovf_d = 1'b1;
      if (ovf_cnt_q != {BLK_W{1'b1}}) ovf_cnt_d = ovf_cnt_q + BLK_W'(1);
    end

    if (state_q == S_ARM) begin
      blocks_d  = '0;
      pend_d    = '0;
      acc_d     = '0;
      icnt_d    = '0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      base_q    <= '0;
      bursts_q  <= '0;
      ring_q    <= '0;
      blen_q    <= '0;
      blkb_q    <= '0;
      bpi_q     <= '0;
      acc_q     <= '0;
      icnt_q    <= '0;
      blocks_q  <= '0;
      pend_q    <= '0;
      ovf_cnt_q <= '0;
      tick_q    <= 1'b0;
      btick_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      irq_blk_q <= 1'b0;
      irq_ovf_q <= 1'b0;
      irq_err_q <= 1'b0;
    end else begin
      base_q    <= base_d;
      bursts_q  <= bursts_d;
      ring_q    <= ring_d;
      blen_q    <= blen_d;
      blkb_q    <= blkb_d;
      bpi_q     <= bpi_d;
      acc_q     <= acc_d;
      icnt_q    <= icnt_d;
      blocks_q  <= blocks_d;
      pend_q    <= pend_d;
      ovf_cnt_q <= ovf_cnt_d;
      tick_q    <= tick_d;
      btick_q   <= bus.dma_write_burst_tick;
      ovf_q     <= bus.dma_write_overflow_ins;
      cfg_err_q <= cfg_err_d;
      irq_blk_q <= irq_blk_d;
      irq_ovf_q <= irq_ovf_d;
      irq_err_q <= irq_err_d;
    end
  end

`ifdef RX_DMA_SCHED_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic        stall_q, stall_d;

  always_comb begin
    wd_d    = wd_q;
    stall_d = 1'b0;
    if ((state_q == S_ARM) || btick_rise) begin
      wd_d = '0;
    end else if (state_q == S_RUN) begin
      if ((bus.cfg_watchdog_cycles != 32'd0) && (wd_q == bus.cfg_watchdog_cycles - 32'd1)) begin
        stall_d = 1'b1;
        wd_d    = '0;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

  assign bus.irq_stall = stall_q;
`else
  assign bus.irq_stall = 1'b0;
`endif

  assign bus.dma_write_enable            = (state_q == S_RUN);
  assign bus.dma_write_base_address      = base_q;
  assign bus.dma_write_burst_count       = bursts_q;
  assign bus.dma_write_burst_len         = blen_q;
  assign bus.dma_write_ddr_size          = ring_q;
  assign bus.dma_write_access_size_bytes = blkb_q;
  assign bus.dma_write_access_tick       = tick_q;
  assign bus.state                       = state_q;
  assign bus.blocks_ready                = blocks_q;
  assign bus.release_pending             = pend_q;
  assign bus.overflow_count              = ovf_cnt_q;
  assign bus.cfg_error                   = cfg_err_q;
  assign bus.irq_block                   = irq_blk_q;
  assign bus.irq_overflow                = irq_ovf_q;
  assign bus.irq_error                   = irq_err_q;
endmodule

// File: tb/tb_rx_dma_sched.sv
// tb/tb_rx_dma_sched.sv - directed vector bench for rx_dma_sched
module tb_rx_dma_sched;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  rx_dma_sched_if bus ();
  rx_dma_sched dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  typedef struct {
    logic       start, stop, btick, rel, ack, busy, ovf;
    logic [1:0] bresp;
    logic [2:0] st;
    logic       en, tick;
    logic [15:0] br;
    logic [7:0] pend;
    logic       irqb, irqe, irqo;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic start, logic stop, logic btick, logic rel, logic ack,
                              logic ovf, logic [1:0] bresp, logic [2:0] st, logic en,
                              logic tick, logic [15:0] br, logic [7:0] pend,
                              logic irqb, logic irqe, logic irqo);
    vec_t v;
    v.start = start; v.stop = stop; v.btick = btick; v.rel = rel; v.ack = ack;
    v.busy = 1'b0; v.ovf = ovf; v.bresp = bresp;
    v.st = st; v.en = en; v.tick = tick; v.br = br; v.pend = pend;
    v.irqb = irqb; v.irqe = irqe; v.irqo = irqo;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(logic start, logic stop, logic btick, logic rel, logic ack, logic busy);
    bus.cfg_start = start; bus.cfg_stop = stop; bus.dma_write_burst_tick = btick;
    bus.host_release = rel; bus.dma_write_access_tick_ack = ack; bus.dma_write_busy = busy;
  endtask

  task automatic set_cfg(logic [8:0] blen, logic [16:0] blkb, logic [7:0] bpi);
    bus.cfg_burst_len = blen; bus.cfg_block_bytes = blkb; bus.cfg_blocks_per_irq = bpi;
  endtask

  function automatic logic [31:0] outs();
    return {bus.state, bus.dma_write_enable, bus.dma_write_access_tick, bus.blocks_ready,
            bus.release_pending, bus.irq_block, bus.irq_error, bus.irq_overflow};
  endfunction

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int first_stall;
    int n_stall;
    drive(0, 0, 0, 0, 0, 0);
    bus.dma_write_overflow_ins = 1'b0;
    bus.dma_write_bresp = 2'b00;
    bus.cfg_base_addr = 48'h1234_5678_9ABC;
    bus.cfg_ring_bytes = 32'h0010_0000;
    bus.cfg_ring_bursts = 32'd4096;
    set_cfg(9'd16, 17'd1024, 8'd2);
`ifdef RX_DMA_SCHED_WATCHDOG_EN
    bus.cfg_watchdog_cycles = 32'd0;
`endif

    //                start stop bt rel ack ovf bresp   st en tk br pend ib ie io
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 3'd1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) begin
      vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'b00, 3'd2, 1, 0, (i >= 3) ? 16'd1 : 16'd0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, (i >= 3) ? 16'd1 : 16'd0, 0, 0, 0, 0));
    end
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'b00, 3'd2, 1, 0, 2, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 2'b00, 3'd2, 1, 0, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 1, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 1, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 3'd2, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 3'd2, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 2'b00, 3'd2, 1, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 1, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 3'd2, 1, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 3'd2, 1, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    end
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 2'b00, 3'd2, 1, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 2'b10, 3'd4, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 3'd4, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 3'd3, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) step();
    chk("reset", {outs(), bus.overflow_count, bus.cfg_error, bus.irq_stall}, 64'd0);
    aresetn = 1'b1;
    step();

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stop, vq[i].btick, vq[i].rel, vq[i].ack, vq[i].busy);
      bus.dma_write_overflow_ins = vq[i].ovf;
      bus.dma_write_bresp = vq[i].bresp;
      step();
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vq[i].st, vq[i].en, vq[i].tick, vq[i].br, vq[i].pend,
               vq[i].irqb, vq[i].irqe, vq[i].irqo}));
    end
    drive(0, 0, 0, 0, 0, 0);
    bus.dma_write_overflow_ins = 1'b0;
    bus.dma_write_bresp = 2'b00;
    chk("ovf_count", 64'(bus.overflow_count), 64'd1);
    chk("shadow", {bus.dma_write_base_address, bus.dma_write_burst_len, 7'd0},
        {48'h1234_5678_9ABC, 9'd16, 7'd0});
    chk("shadow2", {bus.dma_write_burst_count, bus.dma_write_ddr_size}, {32'd4096, 32'h0010_0000});

    // Config validity, including the block_bytes == burst_bytes boundary.
    set_cfg(9'd0, 17'd1024, 8'd2);
    drive(1, 0, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0);
    chk("blen0_err", {bus.cfg_error, bus.state, bus.dma_write_enable}, {1'b1, 3'd0, 1'b0});
    step();
    chk("blen0_idle", {bus.state, bus.dma_write_enable}, {3'd0, 1'b0});
    set_cfg(9'd16, 17'd256, 8'd2);
    drive(1, 0, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0);
    chk("edge_valid", {bus.cfg_error, bus.state, bus.dma_write_access_size_bytes}, {1'b0, 3'd1, 17'd256});
    host_release_ignored: begin
      bus.host_release = 1'b1; step(); bus.host_release = 1'b0;
      chk("arm_rel_ignored", {bus.state, bus.release_pending}, {3'd2, 8'd0});
    end
    drive(0, 1, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0); step();
    chk("back_idle", 64'(bus.state), 64'd0);
    set_cfg(9'd16, 17'd255, 8'd2);
    drive(1, 0, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0);
    chk("small_block_err", {bus.cfg_error, bus.state}, {1'b1, 3'd0});

    // blocks_per_irq = 0 acts as 1; then idle RUN cycles for the watchdog.
    set_cfg(9'd16, 17'd256, 8'd0);
`ifdef RX_DMA_SCHED_WATCHDOG_EN
    bus.cfg_watchdog_cycles = 32'd100;
`endif
    drive(1, 0, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0); step();
    bus.dma_write_burst_tick = 1'b1; step();
    chk("bpi0_a", {bus.irq_block, bus.blocks_ready, bus.cfg_error}, {1'b1, 16'd1, 1'b0});
    bus.dma_write_burst_tick = 1'b0; step();
    chk("bpi0_gap", 64'(bus.irq_block), 64'd0);
    bus.dma_write_burst_tick = 1'b1; step();
    chk("bpi0_b", {bus.irq_block, bus.blocks_ready}, {1'b1, 16'd2});
    bus.dma_write_burst_tick = 1'b0;
    first_stall = 0;
    n_stall = 0;
    for (int i = 1; i <= 150; i++) begin
      step();
      if (bus.irq_stall === 1'b1) begin
        n_stall++;
        if (first_stall == 0) first_stall = i;
      end
    end
`ifdef RX_DMA_SCHED_WATCHDOG_EN
    chk("stall_at", 64'(first_stall), 64'd100);
    chk("stall_count", 64'(n_stall), 64'd1);
`else
    chk("stall_tied0", 64'(n_stall), 64'd0);
`endif
    drive(0, 1, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0); step();
    chk("wd_idle", 64'(bus.state), 64'd0);

    // Drain with DMA busy and a release tick still outstanding.
    set_cfg(9'd16, 17'd1024, 8'd2);
    drive(1, 0, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0); step();
    bus.host_release = 1'b1; step(); bus.host_release = 1'b0; step();
    chk("drain_tick_up", {bus.dma_write_access_tick, bus.release_pending}, {1'b1, 8'd1});
    drive(0, 1, 0, 0, 0, 1); step();
    chk("drain_enter", {bus.state, bus.dma_write_enable, bus.dma_write_access_tick}, {3'd3, 1'b0, 1'b1});
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("drain_busy%0d", i), 64'(bus.state), 64'd3);
    end
    drive(0, 0, 0, 0, 0, 0); step();
    chk("drain_wait_tick", {bus.state, bus.dma_write_access_tick}, {3'd3, 1'b1});
    drive(0, 0, 0, 0, 1, 0); step();
    chk("drain_ack", {bus.state, bus.dma_write_access_tick, bus.release_pending}, {3'd3, 1'b0, 8'd0});
    drive(0, 0, 0, 0, 0, 0); step();
    chk("drain_exit", 64'(bus.state), 64'd0);

    // Asynchronous reset while a release tick is high.
    drive(1, 0, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0, 0); step();
    bus.host_release = 1'b1; step(); bus.host_release = 1'b0; step();
    chk("rst_pre", {bus.dma_write_access_tick, bus.dma_write_enable}, {1'b1, 1'b1});
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_async", {bus.dma_write_access_tick, bus.dma_write_enable, bus.state}, {1'b0, 1'b0, 3'd0});
    step();
    aresetn = 1'b1;
    step();
    chk("rst_after", {outs(), bus.overflow_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
